// File: rtl/writeback_regfile.sv
// Sixteen-entry register file behind a one-entry writeback latch, with four bypassed combinational read ports.
// Latency: a result accepted at edge N is readable in cycle N+1 and committed at N+1. Backpressure: in_ready drops only while the latch is full and frozen.
module writeback_regfile #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       rd_A,
  input  logic [3:0]       rd_B,
  input  logic [3:0]       rd_C,
  input  logic [3:0]       rd_D,
  output logic [WIDTH-1:0] v_A,
  output logic [WIDTH-1:0] v_B,
  output logic [WIDTH-1:0] v_C,
  output logic [WIDTH-1:0] v_D,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Y1,
  input  logic [WIDTH-1:0] Y2,
  input  logic [3:0]       dst1,
  input  logic [3:0]       dst2,
  input  logic             we1,
  input  logic             we2,
  input  logic             freeze,
  output logic             wb_busy,
  output logic [CNT_W-1:0] commit_count
);

  typedef struct packed {
    logic [WIDTH-1:0] y1;
    logic [WIDTH-1:0] y2;
    logic [3:0]       d1;
    logic [3:0]       d2;
    logic             we1;
    logic             we2;
  } wb_ent_t;

  wb_ent_t          lat_q, lat_d;
  logic             lv_q, lv_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] regs_q [16];
  logic             fire;
  logic             commit;
  logic [3:0]       rd_idx [4];
  logic [WIDTH-1:0] rd_dat [4];

  assign in_ready     = !lv_q || !freeze;
  assign fire         = in_valid && in_ready;
  assign commit       = lv_q && !freeze;
  assign wb_busy      = lv_q;
  assign commit_count = cnt_q;

  // Drain and refill may happen on the same edge; a fresh accept overrides the clear.
  always_comb begin
    lat_d = lat_q;
    lv_d  = lv_q;
    cnt_d = cnt_q;
    if (commit) begin
      lv_d  = 1'b0;
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (fire) begin
      lat_d = '{y1: Y1, y2: Y2, d1: dst1, d2: dst2, we1: we1, we2: we2};
      lv_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_q <= '0;
      lv_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      lat_q <= lat_d;
      lv_q  <= lv_d;
      cnt_q <= cnt_d;
    end
  end

  // Y2 is written last so it wins when both results target the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else if (commit) begin
      if (lat_q.we1) regs_q[lat_q.d1] <= lat_q.y1;
      if (lat_q.we2) regs_q[lat_q.d2] <= lat_q.y2;
    end
  end

  assign rd_idx[0] = rd_A;
  assign rd_idx[1] = rd_B;
  assign rd_idx[2] = rd_C;
  assign rd_idx[3] = rd_D;

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      rd_dat[p] = regs_q[rd_idx[p]];
      if (lv_q && lat_q.we1 && (lat_q.d1 == rd_idx[p])) rd_dat[p] = lat_q.y1;
      if (lv_q && lat_q.we2 && (lat_q.d2 == rd_idx[p])) rd_dat[p] = lat_q.y2;
    end
  end

  assign v_A = rd_dat[0];
  assign v_B = rd_dat[1];
  assign v_C = rd_dat[2];
  assign v_D = rd_dat[3];

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: directed scenarios with literal expectations plus a randomized run against a behavioural model.
module tb_writeback_regfile;

  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    rd_A, rd_B, rd_C, rd_D;
  logic [W-1:0]  v_A, v_B, v_C, v_D;
  logic          in_valid, in_ready;
  logic [W-1:0]  Y1, Y2;
  logic [3:0]    dst1, dst2;
  logic          we1, we2, freeze, wb_busy;
  logic [CW-1:0] commit_count;

  int errors = 0;
  int checks = 0;

  writeback_regfile #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_A(rd_A), .rd_B(rd_B), .rd_C(rd_C), .rd_D(rd_D),
    .v_A(v_A), .v_B(v_B), .v_C(v_C), .v_D(v_D),
    .in_valid(in_valid), .in_ready(in_ready),
    .Y1(Y1), .Y2(Y2), .dst1(dst1), .dst2(dst2), .we1(we1), .we2(we2),
    .freeze(freeze), .wb_busy(wb_busy), .commit_count(commit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural array, pending entry, commit total.
  logic [31:0] m_regs [16];
  logic        m_lv;
  logic [31:0] m_y1, m_y2;
  logic [3:0]  m_d1, m_d2;
  logic        m_we1, m_we2;
  int          m_cnt;

  function automatic logic [31:0] m_read(input logic [3:0] idx);
    if (m_lv && m_we2 && m_d2 == idx) return m_y2;
    if (m_lv && m_we1 && m_d1 == idx) return m_y1;
    return m_regs[idx];
  endfunction

  always @(negedge clk) begin
    logic exp_rdy, do_fire, do_commit;
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 0;
      m_lv = 0; m_cnt = 0;
      m_y1 = 0; m_y2 = 0; m_d1 = 0; m_d2 = 0; m_we1 = 0; m_we2 = 0;
    end
    exp_rdy = !m_lv || !freeze;
    chk("m_v_A", v_A, m_read(rd_A));
    chk("m_v_B", v_B, m_read(rd_B));
    chk("m_v_C", v_C, m_read(rd_C));
    chk("m_v_D", v_D, m_read(rd_D));
    chk("m_in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("m_wb_busy", 32'(wb_busy), 32'(m_lv));
    chk("m_commit_count", 32'(commit_count), 32'(m_cnt % 16));
    if (rst_n) begin
      do_fire   = in_valid && exp_rdy;
      do_commit = m_lv && !freeze;
      if (do_commit) begin
        if (m_we1) m_regs[m_d1] = m_y1;
        if (m_we2) m_regs[m_d2] = m_y2;
        m_cnt++;
        m_lv = 0;
      end
      if (do_fire) begin
        m_lv = 1; m_y1 = Y1; m_y2 = Y2; m_d1 = dst1; m_d2 = dst2; m_we1 = we1; m_we2 = we2;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] y1v, input logic [3:0] d1v, input logic w1,
                     input logic [31:0] y2v, input logic [3:0] d2v, input logic w2);
    in_valid = 1; Y1 = y1v; dst1 = d1v; we1 = w1; Y2 = y2v; dst2 = d2v; we2 = w2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; in_valid = 0; freeze = 0; Y1 = 0; Y2 = 0;
    dst1 = 0; dst2 = 0; we1 = 0; we2 = 0;
    rd_A = 0; rd_B = 0; rd_C = 0; rd_D = 0;
    repeat (3) cyc();
    rst_n = 1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_wb_busy", 32'(wb_busy), 32'd0);
    chk("rst_v_A", v_A, 32'd0);
    chk("rst_count", 32'(commit_count), 32'd0);

    // Basic dual write with bypass then array read
    rd_A = 3; rd_B = 7;
    put(32'hDEADBEEF, 4'd3, 1'b1, 32'h12345678, 4'd7, 1'b1);
    cyc();
    in_valid = 0;
    chk("basic_bypass_A", v_A, 32'hDEADBEEF);
    chk("basic_bypass_B", v_B, 32'h12345678);
    chk("basic_busy", 32'(wb_busy), 32'd1);
    cyc();
    chk("basic_array_A", v_A, 32'hDEADBEEF);
    chk("basic_array_B", v_B, 32'h12345678);
    chk("basic_count", 32'(commit_count), 32'd1);

    // Same destination: Y2 wins
    rd_C = 5;
    put(32'h1, 4'd5, 1'b1, 32'h2, 4'd5, 1'b1);
    cyc();
    in_valid = 0;
    chk("samedst_bypass", v_C, 32'h2);
    cyc();
    chk("samedst_array", v_C, 32'h2);
    chk("samedst_count", 32'(commit_count), 32'd2);

    // Freeze holds the latch; new input ignored while blocked
    rd_D = 9;
    put(32'hAAAA0001, 4'd9, 1'b1, 32'h0, 4'd0, 1'b0);
    cyc();
    freeze = 1;
    put(32'h00000BAD, 4'd9, 1'b1, 32'h0, 4'd0, 1'b0);
    #1;
    chk("frz_in_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("frz_busy", 32'(wb_busy), 32'd1);
      chk("frz_bypass", v_D, 32'hAAAA0001);
      chk("frz_count", 32'(commit_count), 32'd2);
    end
    in_valid = 0; freeze = 0;
    #1;
    chk("frz_release_ready", 32'(in_ready), 32'd1);
    cyc();
    chk("frz_commit_busy", 32'(wb_busy), 32'd0);
    chk("frz_commit_val", v_D, 32'hAAAA0001);
    chk("frz_commit_count", 32'(commit_count), 32'd3);

    // Entry with no enables still commits
    rd_A = 3;
    put(32'h0, 4'd3, 1'b0, 32'h0, 4'd3, 1'b0);
    cyc();
    in_valid = 0;
    chk("noen_bypass", v_A, 32'hDEADBEEF);
    cyc();
    chk("noen_array", v_A, 32'hDEADBEEF);
    chk("noen_count", 32'(commit_count), 32'd4);

    // 20 back-to-back results; count goes 4 -> 24, i.e. 8 in four bits
    for (int i = 0; i < 20; i++) begin
      put(32'h1000 + 32'(i), 4'(i % 16), 1'b1, 32'h0, 4'd0, 1'b0);
      #1;
      chk("stream_ready", 32'(in_ready), 32'd1);
      cyc();
    end
    in_valid = 0;
    cyc();
    rd_A = 0; rd_B = 15; rd_C = 3;
    #1;
    chk("stream_reg0", v_A, 32'h1010);
    chk("stream_reg15", v_B, 32'h100F);
    chk("stream_reg3", v_C, 32'h1013);
    chk("stream_count_wrap", 32'(commit_count), 32'd8);
    chk("stream_idle", 32'(wb_busy), 32'd0);

    // Reset mid-cycle with a pending entry
    rd_A = 1; rd_B = 0;
    put(32'h55, 4'd1, 1'b1, 32'h0, 4'd0, 1'b0);
    cyc();
    in_valid = 0; freeze = 1;
    #2 rst_n = 0;
    #1;
    chk("midrst_busy", 32'(wb_busy), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    chk("midrst_count", 32'(commit_count), 32'd0);
    chk("midrst_v_A", v_A, 32'd0);
    chk("midrst_v_B", v_B, 32'd0);
    freeze = 0;
    cyc();
    rst_n = 1;
    cyc();
    chk("midrst_lost", v_A, 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      freeze   = ($urandom_range(0, 4) == 0);
      Y1 = $urandom; Y2 = $urandom;
      dst1 = 4'($urandom_range(0, 15));
      dst2 = ($urandom_range(0, 3) == 0) ? dst1 : 4'($urandom_range(0, 15));
      we1 = 1'($urandom_range(0, 1)); we2 = 1'($urandom_range(0, 1));
      rd_A = 4'($urandom_range(0, 15)); rd_B = dst1; rd_C = dst2;
      rd_D = 4'($urandom_range(0, 15));
      cyc();
    end
    in_valid = 0; freeze = 0;
    repeat (2) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
